// File: rtl/prog_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_seq_pkg                                                     |
// | Purpose : Shared types and constants for the benchmark program sequencer:  |
// |           FSM state encoding, result byte addresses in core data memory,   |
// |           program count and a helper giving the read length per program.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    RUN    = 3'd2,
    READ   = 3'd3,
    CMP    = 3'd4,
    GAP    = 3'd5,
    FINISH = 3'd6
  } state_t;

  localparam logic [7:0] PROD_HI_ADDR = 8'd4;
  localparam logic [7:0] PROD_LO_ADDR = 8'd5;
  localparam logic [7:0] CT_ADDR      = 8'd7;
  localparam logic [7:0] DIST_ADDR    = 8'd127;

  localparam int         NUM_PROGS    = 3;
  localparam logic [1:0] PROG_NONE    = 2'd3;

  // Program 0 returns a 16-bit product (two bytes); the others return one byte.
  function automatic logic [1:0] read_len(input logic [1:0] idx);
    return (idx == 2'd0) ? 2'd2 : 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_sequencer_if                                                |
// | Purpose : Bundles the core control handshake and data-memory read port.    |
// |   dut_rst     : reset to the core (sequencer drives)                       |
// |   done        : core program-complete flag (core drives)                   |
// |   mem_rd_en   : data-memory read strobe (sequencer drives)                 |
// |   mem_addr    : data-memory read address, 8 bits (sequencer drives)        |
// |   mem_rd_data : data-memory read data, 8 bits (memory drives)              |
// |   master = sequencer side, slave = core/memory side                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface prog_sequencer_if;
  logic       dut_rst;
  logic       done;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;

  modport master (
    output dut_rst,
    input  done,
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data
  );

  modport slave (
    input  dut_rst,
    output done,
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : result_reader                                                    |
// | Purpose : Issues a back-to-back burst of 1 or 2 data-memory reads and      |
// |           assembles the returned bytes (first byte = high) into a 16-bit   |
// |           result, raising rdy for one cycle when the last byte is in.      |
// | Ports   : clk, reset (async, active-high)                                  |
// |           go (start burst), nbytes (1 or 2), addr0/addr1 (byte addresses)  |
// |           mem_rd_en/mem_addr (read strobe/address), mem_rd_data (in)       |
// |           rdy (one-cycle done pulse), result (16-bit assembled value)      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module result_reader #(
  parameter int MEM_LAT = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        go,
  input  wire logic [1:0]  nbytes,
  input  wire logic [7:0]  addr0,
  input  wire logic [7:0]  addr1,
  output logic             mem_rd_en,
  output logic [7:0]       mem_addr,
  input  wire logic [7:0]  mem_rd_data,
  output logic             rdy,
  output logic [15:0]      result
);

  logic [1:0]         r_issue_left;  // strobes still to issue after the current one
  logic [7:0]         r_next_addr;
  logic [1:0]         r_cap_left;    // bytes still to capture
  logic [MEM_LAT-1:0] r_pend;        // strobe history; top bit = data valid now

  // Delay line aligning each strobe with the cycle its data is valid.
  generate
    if (MEM_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pend <= '0;
        else       r_pend <= mem_rd_en;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pend <= '0;
        else       r_pend <= {r_pend[MEM_LAT-2:0], mem_rd_en};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_en    <= 1'b0;
      mem_addr     <= 8'd0;
      r_issue_left <= 2'd0;
      r_next_addr  <= 8'd0;
      r_cap_left   <= 2'd0;
      result       <= 16'd0;
      rdy          <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (go) begin
        mem_rd_en    <= 1'b1;
        mem_addr     <= addr0;
        r_next_addr  <= addr1;
        r_issue_left <= nbytes - 2'd1;
        r_cap_left   <= nbytes;
        result       <= 16'd0;
      end else if (r_issue_left != 2'd0) begin
        mem_rd_en    <= 1'b1;
        mem_addr     <= r_next_addr;
        r_issue_left <= r_issue_left - 2'd1;
      end else begin
        mem_rd_en    <= 1'b0;
      end

      // Shift in each byte; a single-byte read leaves the high byte zero.
      if (r_pend[MEM_LAT-1] && !go) begin
        result     <= {result[7:0], mem_rd_data};
        r_cap_left <= r_cap_left - 2'd1;
        if (r_cap_left == 2'd1) rdy <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_sequencer                                                   |
// | Purpose : Runs the core through three benchmark programs in turn (mpy      |
// |           product, match count, min distance): reset, release, wait for    |
// |           done, read result bytes, compare with expected, latch pass/fail. |
// | Ports   : clk, reset (async, active-high), start (begin pulse)             |
// |           bus (master): dut_rst, done, mem_rd_en, mem_addr, mem_rd_data    |
// |           exp_prod/exp_ct/exp_dist: expected results, sampled in CMP       |
// |           prog_idx (3 = none), busy, pass/fail/timeout (bit per program),  |
// |           all_done (sticky until next start)                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int GAP_CYCLES = 1,
  parameter int MEM_LAT    = 1,
  parameter int TIMEOUT    = 1 << 20
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         start,
  prog_sequencer_if.master  bus,
  input  wire logic [15:0]  exp_prod,
  input  wire logic [7:0]   exp_ct,
  input  wire logic [7:0]   exp_dist,
  output logic [1:0]        prog_idx,
  output logic              busy,
  output logic [2:0]        pass,
  output logic [2:0]        fail,
  output logic [2:0]        timeout,
  output logic              all_done
);

  localparam int c_to_w     = $clog2(TIMEOUT + 1);
  localparam int c_wait_max = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int c_wait_w   = (c_wait_max > 1) ? $clog2(c_wait_max) : 1;
  localparam logic [c_to_w-1:0]   c_to_max   = c_to_w'(TIMEOUT);
  localparam logic [c_wait_w-1:0] c_rst_last = c_wait_w'(RST_CYCLES - 1);
  localparam logic [c_wait_w-1:0] c_gap_last = c_wait_w'(GAP_CYCLES - 1);
  localparam logic [1:0]          c_last_prog = 2'(NUM_PROGS - 1);

  state_t              r_state, w_next_state;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [1:0]          r_prog_idx;
  logic [2:0]          r_pass, r_fail, r_timeout;
  logic                r_all_done;

  logic                w_go, w_run_timeout, w_result_ok, w_last;
  logic                w_dut_rst, w_busy;
  logic                w_rdy;
  logic [15:0]         w_result;
  logic [7:0]          w_addr0;

  assign w_last = (r_prog_idx == c_last_prog);

  always_comb begin
    w_addr0 = DIST_ADDR;
    case (r_prog_idx)
      2'd0:    w_addr0 = PROD_HI_ADDR;
      2'd1:    w_addr0 = CT_ADDR;
      default: w_addr0 = DIST_ADDR;
    endcase
  end

  always_comb begin
    w_result_ok = 1'b0;
    case (r_prog_idx)
      2'd0:    w_result_ok = (w_result == exp_prod);
      2'd1:    w_result_ok = (w_result == {8'h00, exp_ct});
      default: w_result_ok = (w_result == {8'h00, exp_dist});
    endcase
  end

  // Next state and FSM outputs.
  always_comb begin
    w_next_state  = r_state;
    w_go          = 1'b0;
    w_run_timeout = 1'b0;
    w_dut_rst     = 1'b1;
    w_busy        = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next_state = RST;
      end
      RST: begin
        if (r_wait_cnt == c_rst_last) w_next_state = RUN;
      end
      RUN: begin
        w_dut_rst = 1'b0;
        // r_to_cnt is zero only in the first RUN cycle, where done may be
        // a leftover from the previous program and is not trusted.
        if (bus.done && (r_to_cnt != '0)) begin
          w_go         = 1'b1;
          w_next_state = READ;
        end else if (r_to_cnt == c_to_max) begin
          w_run_timeout = 1'b1;
          w_next_state  = w_last ? FINISH : GAP;
        end
      end
      READ: begin
        w_dut_rst = 1'b0;
        if (w_rdy) w_next_state = CMP;
      end
      CMP: begin
        w_dut_rst    = 1'b0;
        w_next_state = w_last ? FINISH : GAP;
      end
      GAP: begin
        if (r_wait_cnt == c_gap_last) w_next_state = RST;
      end
      FINISH: begin
        w_busy       = 1'b0;
        w_next_state = IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      r_prog_idx <= PROG_NONE;
      r_pass     <= 3'b000;
      r_fail     <= 3'b000;
      r_timeout  <= 3'b000;
      r_all_done <= 1'b0;
    end else begin
      if (r_state != w_next_state)
        r_wait_cnt <= '0;
      else if ((r_state == RST) || (r_state == GAP))
        r_wait_cnt <= r_wait_cnt + 1'b1;

      // Saturating RUN-cycle counter, restarted every time the core is held.
      if (r_state == RST)
        r_to_cnt <= '0;
      else if ((r_state == RUN) && (r_to_cnt != c_to_max))
        r_to_cnt <= r_to_cnt + 1'b1;

      if ((r_state == IDLE) && start) begin
        r_prog_idx <= 2'd0;
        r_pass     <= 3'b000;
        r_fail     <= 3'b000;
        r_timeout  <= 3'b000;
        r_all_done <= 1'b0;
      end

      if (w_run_timeout) begin
        r_timeout[r_prog_idx] <= 1'b1;
        r_fail[r_prog_idx]    <= 1'b1;
      end

      if (r_state == CMP) begin
        if (w_result_ok) r_pass[r_prog_idx] <= 1'b1;
        else             r_fail[r_prog_idx] <= 1'b1;
      end

      if ((r_state == GAP) && (w_next_state == RST))
        r_prog_idx <= r_prog_idx + 2'd1;

      if ((r_state != FINISH) && (w_next_state == FINISH)) begin
        r_prog_idx <= PROG_NONE;
        r_all_done <= 1'b1;
      end
    end
  end

  result_reader #(
    .MEM_LAT (MEM_LAT)
  ) u_reader (
    .clk         (clk),
    .reset       (reset),
    .go          (w_go),
    .nbytes      (read_len(r_prog_idx)),
    .addr0       (w_addr0),
    .addr1       (PROD_LO_ADDR),
    .mem_rd_en   (bus.mem_rd_en),
    .mem_addr    (bus.mem_addr),
    .mem_rd_data (bus.mem_rd_data),
    .rdy         (w_rdy),
    .result      (w_result)
  );

  assign bus.dut_rst = w_dut_rst;
  assign busy        = w_busy;
  assign prog_idx    = r_prog_idx;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign all_done    = r_all_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_prog_sequencer                                                |
// | Purpose : Self-checking bench for prog_sequencer: behavioural core and     |
// |           256-byte data memory, scoreboard queues for read addresses and   |
// |           final per-program status.                                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_prog_sequencer;

  localparam int RST_CYCLES = 2;
  localparam int GAP_CYCLES = 1;
  localparam int MEM_LAT    = 1;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] exp_prod = 16'd0;
  logic [7:0]  exp_ct = 8'd0;
  logic [7:0]  exp_dist = 8'd0;
  logic [1:0]  prog_idx;
  logic        busy;
  logic [2:0]  pass, fail, timeout;
  logic        all_done;

  prog_sequencer_if bus ();

  prog_sequencer #(
    .RST_CYCLES (RST_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .MEM_LAT    (MEM_LAT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .exp_prod (exp_prod),
    .exp_ct   (exp_ct),
    .exp_dist (exp_dist),
    .prog_idx (prog_idx),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .all_done (all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural core + memory ----------------
  logic [7:0] mem [256];
  int core_delay = 1;     // done rises core_delay cycles after the first RUN cycle
  int hang_prog  = 99;    // program index that never raises done
  bit stale_mode = 1'b0;  // hold done high while core is in reset
  int run_cnt    = 0;
  int rel_cnt    = 0;     // releases seen in the current sequence
  int cur_prog   = -1;

  always @(posedge clk) begin
    if (bus.dut_rst) begin
      run_cnt  <= 0;
      bus.done <= stale_mode;
    end else begin
      run_cnt  <= run_cnt + 1;
      bus.done <= ((run_cnt + 1) >= core_delay) && (cur_prog != hang_prog);
    end
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0] p;
    logic [2:0] f;
    logic [2:0] t;
  } stat_t;

  logic [7:0] addr_q [$];
  stat_t      stat_q [$];

  logic prev_rst = 1'b1;
  logic prev_ad  = 1'b0;
  int   hi_cnt   = 0;
  int   low_cnt  = 0;
  bit   seen_rd  = 1'b0;
  int   ad_rises = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rst = 1'b1;
      prev_ad  = 1'b0;
      hi_cnt   = 0;
      low_cnt  = 0;
      seen_rd  = 1'b0;
      rel_cnt  = 0;
      cur_prog = -1;
    end else begin
      if (all_done && !prev_ad) ad_rises++;
      prev_ad = all_done;
      if (bus.dut_rst) begin
        if (busy) hi_cnt++;
        low_cnt = 0;
        seen_rd = 1'b0;
      end else begin
        if (prev_rst) begin
          check_val("rst_hold", hi_cnt, (rel_cnt == 0) ? RST_CYCLES : (GAP_CYCLES + RST_CYCLES));
          cur_prog = rel_cnt;
          rel_cnt++;
          hi_cnt = 0;
        end
        if (bus.mem_rd_en) begin
          if (!seen_rd) begin
            check_val("release_to_read", low_cnt, core_delay + 1);
            seen_rd = 1'b1;
          end
          check_val("read_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) check_val("read_addr", bus.mem_addr, addr_q.pop_front());
        end else if (!seen_rd) begin
          low_cnt++;
        end
      end
      prev_rst = bus.dut_rst;
    end
  end

  // ---------------- helpers ----------------
  task automatic load_nominal();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[4]   = 8'h00;
    mem[5]   = 8'h96;
    mem[7]   = 8'd9;
    mem[127] = 8'd1;
    exp_prod = 16'd150;
    exp_ct   = 8'd9;
    exp_dist = 8'd1;
  endtask

  function automatic int calc_lat();
    int l;
    l = 1 + 2 * GAP_CYCLES;
    for (int p = 0; p < 3; p++)
      l += RST_CYCLES + ((p == 0) ? 2 : 1) + MEM_LAT + 4;
    return l;
  endfunction

  task automatic push_reads(input logic [2:0] et);
    if (!et[0]) begin addr_q.push_back(8'd4); addr_q.push_back(8'd5); end
    if (!et[1]) addr_q.push_back(8'd7);
    if (!et[2]) addr_q.push_back(8'd127);
  endtask

  task automatic run_seq(input string name, input logic [2:0] ep, input logic [2:0] ef,
                         input logic [2:0] et, input bit chk_lat, input bit poke_start);
    int    lat;
    bit    injected;
    stat_t s;
    stat_q.push_back('{p: ep, f: ef, t: et});
    push_reads(et);
    rel_cnt  = 0;
    cur_prog = -1;
    ad_rises = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    injected = 1'b0;
    while (!all_done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (poke_start && !injected && rel_cnt == 2 && !bus.dut_rst) begin
        start = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val({name, ":all_done"}, all_done, 1);
    if (chk_lat) check_val({name, ":latency"}, lat, calc_lat());
    s = stat_q.pop_front();
    check_val({name, ":pass"}, pass, s.p);
    check_val({name, ":fail"}, fail, s.f);
    check_val({name, ":timeout"}, timeout, s.t);
    check_val({name, ":prog_idx"}, prog_idx, 3);
    check_val({name, ":busy_fin"}, busy, 0);
    // start during the FINISH cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val({name, ":busy_after"}, busy, 0);
    check_val({name, ":all_done_sticky"}, all_done, 1);
    check_val({name, ":all_done_rises"}, ad_rises, 1);
    check_val({name, ":reads_left"}, addr_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, ":dut_rst"}, bus.dut_rst, 1);
    check_val({name, ":mem_rd_en"}, bus.mem_rd_en, 0);
    check_val({name, ":mem_addr"}, bus.mem_addr, 0);
    check_val({name, ":prog_idx"}, prog_idx, 3);
    check_val({name, ":busy"}, busy, 0);
    check_val({name, ":pass"}, pass, 0);
    check_val({name, ":fail"}, fail, 0);
    check_val({name, ":timeout"}, timeout, 0);
    check_val({name, ":all_done"}, all_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    load_nominal();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // 1 nominal
    run_seq("nominal", 3'b111, 3'b000, 3'b000, 1'b1, 1'b0);

    // 2 mismatch on program 1
    mem[7] = 8'd8;
    run_seq("mismatch", 3'b101, 3'b010, 3'b000, 1'b1, 1'b0);

    // 3 program 1 never completes
    load_nominal();
    hang_prog = 1;
    run_seq("timeout", 3'b101, 3'b010, 3'b010, 1'b0, 1'b0);
    hang_prog = 99;

    // 4 done left high through reset and the first RUN cycle
    stale_mode = 1'b1;
    core_delay = 5;
    run_seq("stale", 3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    stale_mode = 1'b0;
    core_delay = 1;

    // 5 start pulsed while program 1 runs
    run_seq("start_busy", 3'b111, 3'b000, 3'b000, 1'b1, 1'b1);

    // 6 reset during the program 0 read burst
    push_reads(3'b000);
    rel_cnt  = 0;
    cur_prog = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.mem_rd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("midread:reached_read", bus.mem_rd_en, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("midread");
    addr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_seq("after_reset", 3'b111, 3'b000, 3'b000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
